// File: rtl/universal_shift_reg_n.sv
// Parametrised universal shift register with rotate, arithmetic-shift and
// clear modes, plus a counted burst engine that repeats a latched operation
// a programmable number of times and pulses done on completion.
module universal_shift_reg_n #(
    parameter int unsigned WIDTH = 8,
    // Derived from WIDTH; sized to hold 0..WIDTH. Not meant to be overridden.
    parameter int unsigned LEN_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] data_in,
    input  logic             msb_in,
    input  logic             lsb_in,
    input  logic             start,
    input  logic [LEN_W-1:0] burst_len,
    output logic [WIDTH-1:0] data_out,
    output logic             msb_out,
    output logic             lsb_out,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] MODE_HOLD = 3'd0;
    localparam logic [2:0] MODE_SHR  = 3'd1;
    localparam logic [2:0] MODE_SHL  = 3'd2;
    localparam logic [2:0] MODE_LOAD = 3'd3;
    localparam logic [2:0] MODE_ROR  = 3'd4;
    localparam logic [2:0] MODE_ROL  = 3'd5;
    localparam logic [2:0] MODE_ASR  = 3'd6;
    localparam logic [2:0] MODE_CLR  = 3'd7;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(WIDTH);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  data_q,  data_d;
    logic [LEN_W-1:0]  cnt_q,   cnt_d;
    logic [2:0]        mode_q,  mode_d;
    logic              done_q,  done_d;
    logic [LEN_W-1:0]  len_clamped;

    // One register operation; serial inputs are taken live on every call.
    function automatic logic [WIDTH-1:0] apply_op(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] d,
        input logic             s_msb,
        input logic             s_lsb,
        input logic [WIDTH-1:0] load_val
    );
        logic [WIDTH-1:0] r;
        r = d;
        case (op)
            MODE_HOLD: r = d;
            MODE_SHR:  r = {s_msb, d[WIDTH-1:1]};
            MODE_SHL:  r = {d[WIDTH-2:0], s_lsb};
            MODE_LOAD: r = load_val;
            MODE_ROR:  r = {d[0], d[WIDTH-1:1]};
            MODE_ROL:  r = {d[WIDTH-2:0], d[WIDTH-1]};
            MODE_ASR:  r = {d[WIDTH-1], d[WIDTH-1:1]};
            MODE_CLR:  r = '0;
        endcase
        return r;
    endfunction

    // Requested burst lengths beyond WIDTH saturate at WIDTH.
    assign len_clamped = (burst_len > LEN_MAX) ? LEN_MAX : burst_len;

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: enter BURST on a nonzero start, leave on last step.
    always_comb begin
        state_d = state_q;
        if (en) begin
            case (state_q)
                S_IDLE: begin
                    if (start && (len_clamped != '0)) begin
                        state_d = S_BURST;
                    end
                end
                S_BURST: begin
                    if (cnt_q == LEN_ONE) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Datapath/output next values; done defaults low so it never sticks.
    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        mode_d = mode_q;
        done_d = 1'b0;
        if (en) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        // Latch the burst; data is untouched on the accept edge.
                        mode_d = mode;
                        cnt_d  = len_clamped;
                        if (len_clamped == '0) begin
                            done_d = 1'b1;
                        end
                    end else begin
                        data_d = apply_op(mode, data_q, msb_in, lsb_in, data_in);
                    end
                end
                S_BURST: begin
                    data_d = apply_op(mode_q, data_q, msb_in, lsb_in, data_in);
                    cnt_d  = cnt_q - LEN_ONE;
                    if (cnt_q == LEN_ONE) begin
                        done_d = 1'b1;
                    end
                end
                default: begin
                    cnt_d = '0;
                end
            endcase
        end
    end

    // Datapath registers; reset aborts any burst without a done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
            cnt_q  <= '0;
            mode_q <= MODE_HOLD;
            done_q <= 1'b0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
            done_q <= done_d;
        end
    end

    assign data_out = data_q;
    assign msb_out  = data_q[WIDTH-1];
    assign lsb_out  = data_q[0];
    assign busy     = (state_q == S_BURST);
    assign done     = done_q;

endmodule

// File: doc/universal_shift_reg_n.md
# universal_shift_reg_n

Parametrised universal shift register with rotate, arithmetic-shift and clear modes, plus a counted burst engine that repeats a latched operation N times and signals completion. It is the next generation of the 4-bit universal shift register. It sits in serialiser, barrel-substitute and test-pattern datapaths, where a controller issues one-cycle operations or fire-and-forget bursts.

## Interface
- WIDTH, 8, register width in bits (≥ 2)
- LEN_W, $clog2(WIDTH+1), width of the burst length field (derived, not overridden)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- en  in  1  clock enable; low freezes all state (data, burst counter, busy)
- mode  in  3  operation select (see Operation)
- data_in  in  WIDTH  parallel load value
- msb_in  in  1  serial input entering bit WIDTH-1 on shift right
- lsb_in  in  1  serial input entering bit 0 on shift left
- start  in  1  burst request, sampled only when idle and en=1
- burst_len  in  LEN_W  number of operations in a burst, 0..WIDTH
- data_out  out  WIDTH  register contents
- msb_out  out  1  data_out[WIDTH-1] (combinational)
- lsb_out  out  1  data_out[0] (combinational)
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse at burst completion

## Operation
- Mode encoding:
  - 0: hold
  - 1: shift right, {msb_in, d[W-1:1]}
  - 2: shift left, {d[W-2:0], lsb_in}
  - 3: parallel load data_in
  - 4: rotate right, {d[0], d[W-1:1]}
  - 5: rotate left, {d[W-2:0], d[W-1]}
  - 6: arithmetic shift right, {d[W-1], d[W-1:1]}
  - 7: clear to 0
- FSM states are IDLE and BURST.
- IDLE, en=1, start=0: the mode operation is applied on every edge (direct mode).
- IDLE, en=1, start=1: mode and burst_len are latched; data is not changed on that edge.
  - burst_len>0: go to BURST with counter=burst_len.
  - burst_len=0: stay in IDLE and pulse done.
- BURST, en=1: apply the latched mode on each edge and decrement the counter. On the edge where the counter goes 1→0, return to IDLE and pulse done.
- BURST: the mode and start inputs are ignored. A start while busy is dropped, not queued.
- burst_len>WIDTH is clamped to WIDTH.
- en=0: no state changes. done still deasserts on the next edge, so it is never held high.
- serial inputs are sampled live on every burst step, not latched.

## Timing
- Reset (rst=0, asynchronous): data_out=0, busy=0, done=0, FSM=IDLE, counter=0. Outputs take these values immediately, without waiting for a clock edge.
- Release of reset: the first active edge is the first edge with rst=1.
- Direct-mode latency: 1 cycle, so data_out reflects the op after the edge it was sampled on.
- Burst timing, with start sampled at edge k and en held high:
  - busy=1 after edge k
  - ops occur at edges k+1..k+N
  - after edge k+N: busy=0, done=1 for exactly one cycle
- With en low for E cycles inside a burst, completion moves to edge k+N+E.
- Back-to-back bursts: start may be asserted in the same cycle done=1. It is accepted, because the FSM is IDLE in that cycle.
- Reset mid-burst aborts the burst. No done pulse is generated.

## Test plan
- Reset and load: rst=0 with data_out nonzero gives data_out=0x00 immediately. Then mode=3, data_in=0xA5, one edge gives 0xA5, msb_out=1, lsb_out=1.
- All direct modes from 0x96:
  - mode 1 with msb_in=1 → 0xCB
  - mode 2 with lsb_in=0 → 0x2C
  - mode 4 → 0x4B
  - mode 5 → 0x2D
  - mode 6 → 0xCB
  - mode 7 → 0x00
  - mode 0 → unchanged
- Burst rotate: data 0x81, start with mode=5, burst_len=3. busy is high for 3 cycles, data goes 0x03, 0x06, 0x0C, then done pulses once. Mode toggling during the burst has no effect.
- Burst with stall and ignored start: shift right burst of 4 on 0xF0 with msb_in=0, en=0 for 2 cycles mid-burst. Result is 0x0F, done comes 2 cycles later, and a start while busy is ignored.
- Edge lengths:
  - burst_len=0: done pulses the next cycle, busy never rises, data unchanged
  - burst_len=8 (WIDTH) rotate: data returns to its original value
- Reset mid-burst: rst low at step 2 of a 5-step burst gives busy=0, data=0, and no done. The next start is accepted normally.
